imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 16384, instruction memory depth in 32-bit words; power of two, at most 16384.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, idle cycles between received bytes before a partial frame is discarded.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle pulse from the UART receiver: rx_data holds a new byte.
REQ-006 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-007 imem_addr  input  16  CPU fetch byte address; word index = imem_addr[15:2] modulo IMEM_WORDS.
REQ-008 imem_rd_data  output  32  instruction word; synchronous read.
REQ-009 cpu_rst  output  1  active-high reset to the core; held at 1 until a load completes successfully.
REQ-010 load_done  output  1  program loaded and checksum verified.
REQ-011 load_err  output  1  frame rejected; sticky until rst_n.

Function
REQ-012 Frame format: 4-byte word count LEN, LSB first; then LEN words of 4 bytes each, LSB first; then 1 checksum byte equal to the XOR of all payload bytes (header excluded).
REQ-013 FSM states: WAIT_LEN, DATA, CSUM, RUN, ERROR; only accepted bytes (rx_valid=1) advance byte and word counters.
REQ-014 WAIT_LEN: 4th header byte completes LEN; LEN=0 or LEN>IMEM_WORDS -> ERROR, else -> DATA with word pointer=0, byte index=0, checksum=0.
REQ-015 DATA: every byte XORed into the checksum; on the 4th byte of a word, the assembled word is written to mem[pointer] at that same clock edge and the pointer increments; after word LEN is written -> CSUM.
REQ-016 CSUM: next byte equal to the checksum -> RUN; cpu_rst=0 and load_done=1 from that clock edge. Mismatch -> ERROR.
REQ-017 RUN: rx_valid ignored; cpu_rst, load_done and memory contents unchanged until rst_n.
REQ-018 ERROR: load_err=1, cpu_rst=1, load_done=0; rx_valid ignored; exit only by rst_n.
REQ-019 Idle counter: active in WAIT_LEN after at least one header byte, and in DATA and CSUM; cleared on every accepted byte; on reaching TIMEOUT_CYCLES the FSM returns to WAIT_LEN with all counters, LEN and checksum cleared. Words already written are kept.
REQ-020 rx_valid in the same cycle as timeout expiry: the byte is accepted and the timeout does not fire.
REQ-021 Read port: imem_rd_data <= mem[index] on every clock edge in all states; one-cycle latency.
REQ-022 A read and a write to the same index in the same cycle return the old contents (read-before-write).
REQ-023 Unwritten memory locations read as undefined; no memory initialisation is required.

Reset
REQ-024 rst_n=0 forces WAIT_LEN, cpu_rst=1, load_done=0, load_err=0, imem_rd_data=0, and clears all counters, LEN and checksum; memory contents are not cleared.
REQ-025 Reset asserted during any state, including mid-DATA, aborts the load; the next frame after release is handled from WAIT_LEN.

Verification
REQ-026 Reset -> cpu_rst=1, load_done=0, load_err=0, imem_rd_data=0.
REQ-027 Bytes 02 00 00 00 93 00 00 00 13 01 10 00 91 -> cpu_rst=0, load_done=1 after the last byte; imem_addr=0x0004 -> imem_rd_data=0x00100113 one cycle later; imem_addr=0x0000 -> 0x00000093.
REQ-028 Same frame with checksum byte 90 -> load_err=1, cpu_rst stays 1; later bytes produce no change.
REQ-029 Header 00 00 00 00, and separately a header of IMEM_WORDS+1 -> ERROR on the 4th header byte.
REQ-030 Two header bytes, then TIMEOUT_CYCLES idle, then the full frame from REQ-027 -> loads correctly, load_done=1. Repeat with a byte arriving exactly on the expiry cycle -> the byte is accepted (REQ-020).
REQ-031 rst_n pulsed mid-DATA, then the frame from REQ-027 -> normal completion with the new contents readable.

Source files
------------

// File: rtl/imem_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed program image
// into a synchronous instruction memory and releases the core once it verifies.
module imem_loader #(
    parameter int unsigned IMEM_WORDS     = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [15:0] imem_addr,
    output logic [31:0] imem_rd_data,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        WAIT_LEN,
        DATA,
        CSUM,
        RUN,
        ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   len_q, len_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          load_done_q, load_done_d;
    logic          load_err_q, load_err_d;
    logic [31:0]   rd_data_q;

    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [31:0]   mem_wdata_c;
    logic [31:0]   shifted_c;
    logic          timer_active_c;
    logic [13:0]   word_idx_c;
    logic [AW-1:0] mem_raddr_c;
    logic          unused_bits_c;

    logic [31:0] mem [IMEM_WORDS];

    assign word_idx_c    = imem_addr[15:2];
    assign mem_raddr_c   = word_idx_c[AW-1:0];
    assign unused_bits_c = ^{imem_addr[1:0], word_idx_c};

    // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
    assign shifted_c = {rx_data, word_q[31:8]};

    assign timer_active_c = ((state_q == WAIT_LEN) && (byte_idx_q != 2'd0)) ||
                            (state_q == DATA) || (state_q == CSUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LEN;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'd0;
            len_q       <= 32'd0;
            ptr_q       <= PW'(0);
            csum_q      <= 8'd0;
            idle_q      <= TW'(0);
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            csum_q      <= csum_d;
            idle_q      <= idle_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        csum_d      = csum_q;
        idle_d      = idle_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = ptr_q[AW-1:0];
        mem_wdata_c = shifted_c;

        unique case (state_q)
            WAIT_LEN: begin
                if (rx_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = shifted_c;
                    if (byte_idx_q == 2'd3) begin
                        len_d  = shifted_c;
                        word_d = 32'd0;
                        ptr_d  = PW'(0);
                        csum_d = 8'd0;
                        if ((shifted_c == 32'd0) || (shifted_c > 32'(IMEM_WORDS))) begin
                            state_d = ERROR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = shifted_c;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_c = 1'b1;
                        word_d   = 32'd0;
                        ptr_d    = ptr_q + PW'(1);
                        if ((32'(ptr_q) + 32'd1) == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? RUN : ERROR;
                end
            end
            default: begin
            end
        endcase

        // Idle watchdog: a byte on the expiry cycle wins over the timeout.
        if (rx_valid || !timer_active_c) begin
            idle_d = TW'(0);
        end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = WAIT_LEN;
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
            len_d      = 32'd0;
            ptr_d      = PW'(0);
            csum_d     = 8'd0;
            idle_d     = TW'(0);
        end else begin
            idle_d = idle_q + TW'(1);
        end

        cpu_rst_d   = (state_d != RUN);
        load_done_d = (state_d == RUN);
        load_err_d  = (state_d == ERROR);
    end

    // Memory array is intentionally not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read-before-write falls out of non-blocking update ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 32'd0;
        end else begin
            rd_data_q <= mem[mem_raddr_c];
        end
    end

    assign imem_rd_data = rd_data_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected status/read values,
// a negedge monitor pops and compares them when they fall due.
module tb_imem_loader;

    localparam int unsigned W = 16;
    localparam int unsigned T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [15:0] imem_addr = 16'd0;
    logic [31:0] imem_rd_data;
    logic        cpu_rst, load_done, load_err;

    imem_loader #(.IMEM_WORDS(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          due;
        logic        is_rd;
        logic [2:0]  st;
        logic [31:0] rd;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (e.is_rd) begin
                if (imem_rd_data !== e.rd) begin
                    failures++;
                    $display("FAIL %s: rd_data got %h want %h", n, imem_rd_data, e.rd);
                end
            end else if ({cpu_rst, load_done, load_err} !== e.st) begin
                failures++;
                $display("FAIL %s: {cpu_rst,done,err} got %b want %b", n,
                         {cpu_rst, load_done, load_err}, e.st);
            end
        end
    end

    task automatic expect_status(input string n, input logic c, input logic d, input logic e);
        exp_t x;
        x = '{due: cyc + 1, is_rd: 1'b0, st: {c, d, e}, rd: 32'd0};
        exp_q.push_back(x);
        name_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic expect_read(input string n, input logic [15:0] a, input logic [31:0] v);
        exp_t x;
        imem_addr = a;
        x = '{due: cyc + 1, is_rd: 1'b1, st: 3'd0, rd: v};
        exp_q.push_back(x);
        name_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_arr(input logic [7:0] s[16], input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    logic [7:0] frame_a [16];
    logic [7:0] frame_bad [16];
    logic [7:0] frame_b [16];
    logic [7:0] junk [16];

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_a   = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                      8'h13, 8'h01, 8'h10, 8'h00, 8'h91, 8'h00, 8'h00, 8'h00};
        frame_bad = frame_a;
        frame_bad[12] = 8'h90;
        frame_b   = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                      8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h00, 8'h00, 8'h00};
        junk      = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55, 8'h55, 8'h55,
                      8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};

        // Reset values observed while rst_n is held low.
        idle(2);
        expect_status("reset_status", 1'b1, 1'b0, 1'b0);
        expect_read("reset_rd", 16'h0000, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Good frame.
        send_arr(frame_a, 0, 11);
        expect_status("before_csum", 1'b1, 1'b0, 1'b0);
        send_byte(frame_a[12]);
        expect_status("load_ok", 1'b0, 1'b1, 1'b0);
        expect_read("rd_word1", 16'h0004, 32'h00100113);
        expect_read("rd_word0", 16'h0000, 32'h00000093);
        expect_read("rd_modulo", 16'h0044, 32'h00100113);
        send_arr(junk, 0, 15);
        expect_status("run_ignores_rx", 1'b0, 1'b1, 1'b0);
        expect_read("run_mem_kept", 16'h0000, 32'h00000093);

        // Bad checksum, then later bytes ignored.
        pulse_reset();
        expect_status("post_reset", 1'b1, 1'b0, 1'b0);
        send_arr(frame_bad, 0, 12);
        expect_status("bad_csum", 1'b1, 1'b0, 1'b1);
        send_arr(frame_a, 0, 12);
        expect_status("err_sticky", 1'b1, 1'b0, 1'b1);

        // LEN = 0.
        pulse_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        expect_status("len0_3bytes", 1'b1, 1'b0, 1'b0);
        send_byte(8'h00);
        expect_status("len0_err", 1'b1, 1'b0, 1'b1);

        // LEN = IMEM_WORDS+1 rejected, LEN = IMEM_WORDS accepted.
        pulse_reset();
        send_byte(8'h11); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        expect_status("len_over", 1'b1, 1'b0, 1'b1);
        pulse_reset();
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        expect_status("len_max_ok", 1'b1, 1'b0, 1'b0);

        // Timeout discards a partial header.
        pulse_reset();
        send_arr(frame_a, 0, 1);
        idle(T);
        send_arr(frame_a, 0, 12);
        expect_status("timeout_reload", 1'b0, 1'b1, 1'b0);
        expect_read("timeout_rd", 16'h0004, 32'h00100113);

        // Byte on the expiry cycle is accepted; frame continues.
        pulse_reset();
        send_arr(frame_a, 0, 1);
        idle(T - 1);
        send_arr(frame_a, 2, 12);
        expect_status("expiry_byte_kept", 1'b0, 1'b1, 1'b0);

        // Reset mid-DATA, then a fresh frame.
        pulse_reset();
        send_arr(frame_a, 0, 5);
        pulse_reset();
        expect_status("mid_data_reset", 1'b1, 1'b0, 1'b0);
        send_arr(frame_b, 0, 12);
        expect_status("reload_ok", 1'b0, 1'b1, 1'b0);
        expect_read("reload_w0", 16'h0000, 32'h11223344);
        expect_read("reload_w1", 16'h0004, 32'hAABBCCDD);

        idle(3);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
